// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// UART transmitter fed by a byte FIFO. Bytes are accepted over a valid/ready
// handshake, queued, and sent on the serial line LSB first. Frames follow one
// another with no idle gap while the FIFO holds data.
//
// Handshake: a byte is taken on every rising clock edge where
// tx_valid && tx_ready. tx_ready depends only on the registered fill count.
// A full FIFO therefore refuses a byte even on an edge that also pops.
//
// Parameters:
//   DIVISOR    - clocks per serial bit (2..65535)
//   FIFO_DEPTH - byte entries, power of two (2..256)
//
// Optional feature:
//   UART_TX_PARITY_EN - when defined, an even-parity bit follows data bit 7
//                       (8E1). When undefined, frames are 8N1.
//
// Ports:
//   clock      in   core clock; all logic runs on the rising edge
//   resetb     in   asynchronous active-low reset
//   tx_data    in   byte to send
//   tx_valid   in   tx_data is valid this cycle
//   tx_ready   out  FIFO can accept a byte
//   tx         out  registered serial line, idle high
//   busy       out  a frame is in progress or the FIFO is non-empty
//   fifo_count out  bytes held in the FIFO (excludes the byte being shifted)
module uart_tx_fifo #(
    parameter int DIVISOR    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clock,
    input  logic                        resetb,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]     BIT_LAST = 16'(DIVISOR - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    logic [15:0]   r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;

    state_t        w_state_nxt;
    logic [15:0]   w_timer_nxt;
    logic [2:0]    w_bit_idx_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_tx_nxt;
    logic          w_pop;
    logic          w_push;
    logic          w_not_empty;
    logic          w_timer_done;
    logic [7:0]    w_head;

    assign w_not_empty  = (r_count != '0);
    assign w_timer_done = (r_timer == 16'd0);
    assign w_head       = r_mem[r_rd_ptr];
    assign tx_ready     = (r_count != FULL_CNT);
    assign w_push       = tx_valid && tx_ready;
    assign tx           = r_tx;
    assign busy         = (r_state != ST_IDLE) || w_not_empty;
    assign fifo_count   = r_count;

    // Storage has no reset; only the pointers and the count define its contents.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is latched when the byte is popped, before it is shifted away.
    logic r_parity;
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    // The next line value is computed together with the next state, so tx
    // changes on the same edge as the state it belongs to.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_not_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_timer_nxt = BIT_LAST;
                    w_state_nxt = ST_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (!w_timer_done) begin
                    w_timer_nxt = r_timer - 16'd1;
                end else begin
                    w_timer_nxt   = BIT_LAST;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = ST_DATA;
                    w_tx_nxt      = r_shift[0];
                end
            end
            ST_DATA: begin
                if (!w_timer_done) begin
                    w_timer_nxt = r_timer - 16'd1;
                end else begin
                    w_timer_nxt = BIT_LAST;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (!w_timer_done) begin
                    w_timer_nxt = r_timer - 16'd1;
                end else begin
                    w_timer_nxt = BIT_LAST;
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (!w_timer_done) begin
                    w_timer_nxt = r_timer - 16'd1;
                end else if (w_not_empty) begin
                    // Chain straight into the next start bit: no idle gap.
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_timer_nxt = BIT_LAST;
                    w_state_nxt = ST_START;
                    w_tx_nxt    = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int DIV_A = 434;
    localparam int DIV_B = 2;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clock;
    logic       resetb;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b;
    logic       tx_ready_a, tx_ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;
    logic [4:0] fifo_count_a, fifo_count_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_first, t_last, t_acc;
    logic [7:0] exp_qa[$];
    logic [7:0] exp_qb[$];

    uart_tx_fifo #(.DIVISOR(DIV_A), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .clock(clock), .resetb(resetb), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a), .fifo_count(fifo_count_a)
    );

    uart_tx_fifo #(.DIVISOR(DIV_B), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .clock(clock), .resetb(resetb), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b), .fifo_count(fifo_count_b)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
        checks++;
        assert (obsv === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obsv, expv);
        end
    endtask

    function automatic logic get_tx(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    // Waits for a start bit, then samples every clock of every bit; a bit is
    // only accepted if the line holds the same value for its whole duration.
    task automatic rx_frame(input bit sel, input int div, input int limit,
                            output logic [7:0] data, output int t_fall,
                            output logic ok, output logic par);
        logic [10:0] bits;
        logic        stable;
        int          w;
        bits = '1; stable = 1'b1; w = 0;
        data = 'x; t_fall = cyc; ok = 1'b0; par = 1'bx;
        do begin
            @(negedge clock);
            w++;
        end while (get_tx(sel) !== 1'b0 && w < limit);
        if (get_tx(sel) !== 1'b0) return;
        t_fall = cyc;
        for (int j = 0; j < NB; j++) begin
            for (int k = 0; k < div; k++) begin
                if (j != 0 || k != 0) @(negedge clock);
                if (k == 0) bits[j] = get_tx(sel);
                else if (get_tx(sel) !== bits[j]) stable = 1'b0;
            end
        end
        data = bits[8:1];
        par  = bits[9];
        ok   = stable && (bits[0] === 1'b0) && (bits[NB-1] === 1'b1);
    endtask

    // scoreboard: decode one frame and compare it with the queue head
    task automatic rx_check(input bit sel, input int div, input int limit,
                            output int t_fall, output logic [7:0] data);
        logic       ok, par;
        logic [8:0] expv;
        rx_frame(sel, div, limit, data, t_fall, ok, par);
        check(sel ? "b_frame_ok" : "a_frame_ok", 32'(ok), 32'd1);
        if (sel) expv = (exp_qb.size() != 0) ? {1'b0, exp_qb.pop_front()} : 9'h100;
        else     expv = (exp_qa.size() != 0) ? {1'b0, exp_qa.pop_front()} : 9'h100;
        check(sel ? "b_byte" : "a_byte", 32'({1'b0, data}), 32'(expv));
`ifdef UART_TX_PARITY_EN
        check(sel ? "b_parity" : "a_parity", 32'(par), 32'(^expv[7:0]));
`endif
    endtask

    // driver: single byte into the DIVISOR=434 instance, full frame checks
    task automatic send_a(input logic [7:0] b);
        int         t_fall, w;
        logic [7:0] d;
        @(negedge clock); tx_data_a = b; tx_valid_a = 1'b1;
        @(posedge clock); exp_qa.push_back(b);
        @(negedge clock); tx_valid_a = 1'b0; t_acc = cyc;
        check("a_count_after_push", 32'(fifo_count_a), 32'd1);
        check("a_tx_idle_before_pop", 32'(tx_a), 32'd1);
        rx_check(1'b0, DIV_A, 20, t_fall, d);
        check("a_start_latency", t_fall - t_acc, 32'd1);
        w = 0;
        while (busy_a !== 1'b0 && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("a_busy_drop", cyc - t_fall, NB * DIV_A);
        check("a_tx_idle_after", 32'(tx_a), 32'd1);
    endtask

    // driver: tx_valid held high with 18 bytes 0x00..0x11
    task automatic drive_stream_b();
        int   acc, guard;
        logic rdy;
        acc = 0; guard = 0;
        @(negedge clock); tx_valid_b = 1'b1; tx_data_b = 8'h00;
        while (acc < 18 && guard < 400) begin
            rdy = tx_ready_b;
            @(posedge clock);
            if (rdy === 1'b1) begin
                exp_qb.push_back(tx_data_b);
                acc++;
            end
            @(negedge clock);
            guard++;
            if (rdy === 1'b1) begin
                if (acc == 1) t_first = cyc;
                if (acc == 17) begin
                    check("b_full_count", 32'(fifo_count_b), 32'd16);
                    check("b_full_ready", 32'(tx_ready_b), 32'd0);
                end
                if (acc == 18) begin
                    t_last = cyc;
                    tx_valid_b = 1'b0;
                end
                tx_data_b = 8'(acc);
            end
        end
        check("b_accepted", acc, 32'd18);
        check("b_18th_accept_time", t_last - t_first, NB * DIV_B + 2);
    endtask

    task automatic drive_pair_b(input logic [7:0] x, input logic [7:0] y);
        @(negedge clock); tx_data_b = x; tx_valid_b = 1'b1;
        @(posedge clock); exp_qb.push_back(x);
        @(negedge clock); t_acc = cyc; tx_data_b = y;
        @(posedge clock); exp_qb.push_back(y);
        @(negedge clock); tx_valid_b = 1'b0;
    endtask

    task automatic monitor_b(input int n, output int first_fall);
        int         tf, prev;
        logic [7:0] d;
        first_fall = 0; prev = 0;
        for (int i = 0; i < n; i++) begin
            rx_check(1'b1, DIV_B, 400, tf, d);
            if (i == 0) first_fall = tf;
            else check("b_frame_gap", tf - prev, NB * DIV_B);
            prev = tf;
        end
    endtask

    task automatic wait_idle_b();
        int w;
        w = 0;
        while (busy_b !== 1'b0 && w < 200) begin
            @(negedge clock);
            w++;
        end
    endtask

    initial begin
        int ff, w, lows, busys;
        resetb = 1'b0;
        tx_data_a = 8'h00; tx_valid_a = 1'b0;
        tx_data_b = 8'h00; tx_valid_b = 1'b0;
        repeat (3) @(negedge clock);

        // reset state
        check("rst_tx_a", 32'(tx_a), 32'd1);
        check("rst_ready_a", 32'(tx_ready_a), 32'd1);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_count_a", 32'(fifo_count_a), 32'd0);
        check("rst_tx_b", 32'(tx_b), 32'd1);
        check("rst_ready_b", 32'(tx_ready_b), 32'd1);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_count_b", 32'(fifo_count_b), 32'd0);
        @(negedge clock); resetb = 1'b1;
        repeat (2) @(negedge clock);

        // '7' at DIVISOR=434
        send_a(8'h37);

        // reset in the middle of a queued 4-byte burst
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); tx_data_a = 8'hA0 + 8'(i); tx_valid_a = 1'b1;
            @(posedge clock);
        end
        @(negedge clock); tx_valid_a = 1'b0;
        w = 0;
        while (tx_a !== 1'b0 && w < 20) begin
            @(negedge clock);
            w++;
        end
        check("a_burst_started", 32'(tx_a), 32'd0);
        repeat (3 * DIV_A) @(negedge clock);
        check("a_burst_count_pre_rst", 32'(fifo_count_a), 32'd3);
        check("a_burst_tx_low_pre_rst", 32'(tx_a), 32'd0);
        @(posedge clock); #2 resetb = 1'b0; #1;
        check("a_async_rst_tx", 32'(tx_a), 32'd1);
        check("a_async_rst_busy", 32'(busy_a), 32'd0);
        check("a_async_rst_count", 32'(fifo_count_a), 32'd0);
        check("a_async_rst_ready", 32'(tx_ready_a), 32'd1);
        @(negedge clock); resetb = 1'b1;
        lows = 0; busys = 0;
        for (int i = 0; i < 2 * NB * DIV_A; i++) begin
            @(negedge clock);
            if (tx_a !== 1'b1) lows++;
            if (busy_a !== 1'b0) busys++;
        end
        check("a_residual_tx_lows", lows, 32'd0);
        check("a_residual_busy", busys, 32'd0);
        send_a(8'h5A);

        // 18-byte stream into a 16-deep FIFO at DIVISOR=2
        fork
            drive_stream_b();
            monitor_b(18, ff);
        join
        check("b_stream_first_latency", ff - t_first, 32'd1);
        wait_idle_b();
        check("b_stream_idle_busy", 32'(busy_b), 32'd0);
        check("b_stream_idle_count", 32'(fifo_count_b), 32'd0);

        // 0x55 then 0xAA back-to-back
        fork
            drive_pair_b(8'h55, 8'hAA);
            monitor_b(2, ff);
        join
        check("b_55aa_latency", ff - t_acc, 32'd1);
        wait_idle_b();

        // 0xFF then 0x00: two frames, 2*NB*DIVISOR clocks in total
        fork
            drive_pair_b(8'hFF, 8'h00);
            monitor_b(2, ff);
        join
        wait_idle_b();
        check("b_ff00_total", cyc - ff, 2 * NB * DIV_B);
        check("b_ff00_tx_idle", 32'(tx_b), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synthesizable UART transmitter with an input byte FIFO. Drives the user-project serial TX pin (mprj_io[6]) toward the off-chip UART monitor at 115200 baud from the 50 MHz core clock. Accepts bytes over a valid/ready handshake and serialises them 8N1, LSB first, back-to-back with no idle gap while the FIFO holds data.

## Interface
- DIVISOR, 434, clocks per serial bit (50 MHz / 115200); legal range 2..65535
- FIFO_DEPTH, 16, byte entries; power of two, 2..256
- clock  input  1  core clock, all logic on posedge
- resetb  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- tx_data  input  8  byte to send
- tx_valid  input  1  tx_data is valid this cycle
- tx_ready  output  1  FIFO can accept a byte; reset value 1
- tx  output  1  serial line, idle high; reset value 1
- busy  output  1  frame in progress or FIFO non-empty; reset value 0
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes held in FIFO (excludes byte in shift register); reset value 0

## Operation
- Push: byte written on posedge where tx_valid && tx_ready. tx_ready = (fifo_count != FIFO_DEPTH), from registered count only; a push while full is refused even if a pop occurs the same edge.
- Simultaneous push and pop (non-full): count unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH; count saturates by construction, never exceeds FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: tx=1. If fifo_count!=0, pop head into 8-bit shift register, go START.
- START: tx=0 for DIVISOR clocks, then DATA with bit index 0.
- DATA: tx=shift[0] for DIVISOR clocks per bit; shift right after each bit; after bit 7 go PARITY (if enabled) else STOP.
- STOP: tx=1 for DIVISOR clocks. At final clock: if fifo_count!=0, pop and go directly to START (no idle gap); else go IDLE.
- Bit timer: down-counter loaded with DIVISOR-1 on each state/bit entry; bit ends when it reaches 0.
- busy = (state != IDLE) || (fifo_count != 0).
- tx is a registered output; no glitches.

## Timing
- Push into empty FIFO at edge N while IDLE: pop at edge N+1, tx falls after edge N+1 (1-cycle latency).
- Frame length exactly 10*DIVISOR clocks (11*DIVISOR with parity); back-to-back frames contiguous.
- fifo_count reflects pushes/pops on the edge after they occur.
- Reset asserted mid-frame: tx returns to 1, state IDLE, FIFO flushed, count 0, tx_ready 1 immediately (asynchronously); partial frame discarded. Release on any edge; first push after release behaves as from reset.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state inserted after bit 7, tx = even parity (XOR of 8 data bits) for DIVISOR clocks; frame 11 bit-times (8E1).
- Undefined: no PARITY state, 8N1, 10 bit-times per frame.

## Test plan
- DIVISOR=434, reset then push 0x37 ('7') -> tx low one cycle after accept; bits 1,1,1,0,1,1,0,0 each 434 clocks; stop high; busy drops exactly 4340 clocks after tx falls; monitor decodes '7'.
- FIFO_DEPTH=16, tx_valid held high from reset with 18 bytes 0x00..0x11 -> 17 accepted (first popped one cycle after push), tx_ready low with fifo_count=16; 18th accepted one cycle after first STOP ends; all 18 bytes emerge in order with no gap between frames.
- Push 0x55 and 0xAA back-to-back -> tx shows start,1,0,1,0,1,0,1,0,stop, start,0,1,0,1,0,1,0,1,stop; second start begins on the clock after first stop's last clock.
- Assert resetb low mid-DATA of a queued 4-byte burst -> tx=1, busy=0, fifo_count=0, tx_ready=1 without waiting for clock; after release no residual bits transmitted.
- UART_TX_PARITY_EN, push 0x37 (five ones) -> parity bit 1, frame 11*DIVISOR clocks; push 0x03 -> parity bit 0.
- DIVISOR=2, push 0xFF then 0x00 -> each bit exactly 2 clocks, total 40 clocks for both frames.
